// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: parity and stop-bit
// encodings, the transmit state encoding and the parity rule.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    localparam logic STOP_ONE = 1'b0;
    localparam logic STOP_TWO = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } tx_state_t;

    // Parity bit for a byte: odd -> ~^data, even -> ^data, otherwise 0.
    function automatic logic parity_calc(input logic [7:0] data, input logic [1:0] ptype);
        logic p_s;
        case (ptype)
            PAR_ODD:  p_s = ~^data;
            PAR_EVEN: p_s = ^data;
            PAR_NONE: p_s = 1'b0;
            default:  p_s = 1'b0;
        endcase
        return p_s;
    endfunction

    // Only the odd and even encodings add a parity bit to the frame.
    function automatic logic parity_enabled(input logic [1:0] ptype);
        logic en_s;
        case (ptype)
            PAR_ODD:  en_s = 1'b1;
            PAR_EVEN: en_s = 1'b1;
            PAR_NONE: en_s = 1'b0;
            default:  en_s = 1'b0;
        endcase
        return en_s;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and raises a registered
// one-cycle bit_end strobe while the count sits at its last value.
// clear realigns the count to 0 so a new frame starts on a fresh bit.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             bit_end_r;

    // Next count: restart on clear or at the end of a bit, otherwise advance.
    always_comb begin
        count_nxt_s = count_r;
        if (clear) begin
            count_nxt_s = '0;
        end else if (count_r == LAST_CNT) begin
            count_nxt_s = '0;
        end else begin
            count_nxt_s = count_r + CNT_ONE;
        end
    end

    // Count register plus strobe, registered so bit_end tracks count_r == LAST_CNT.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_r   <= '0;
            bit_end_r <= 1'b0;
        end else begin
            count_r   <= count_nxt_s;
            bit_end_r <= (count_nxt_s == LAST_CNT);
        end
    end

    assign bit_end = bit_end_r;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: latches a byte and its framing on accept, then
// drives start, 8 data bits LSB-first, optional parity and 1 or 2 stop bits.
// done pulses in the first IDLE cycle, where a new send is already accepted,
// so frames can run back to back without an idle bit between them.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  send,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            parity_type,
    input  logic                  stop_bits,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  done
);

    localparam logic [2:0] LAST_IDX = 3'(DATA_WIDTH - 1);
    localparam logic [2:0] IDX_ONE  = 3'd1;

    tx_state_t             state_r;
    logic [DATA_WIDTH-1:0] shreg_r;
    logic [2:0]            bit_idx_r;
    logic                  parity_r;
    logic                  par_en_r;
    logic                  stop_sel_r;
    logic                  tx_out_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  accept_s;
    logic                  bit_end_s;

    assign accept_s = send & (state_r == IDLE);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (accept_s),
        .bit_end (bit_end_s)
    );

    // Frame sequencer: state, shift register, latched framing and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            shreg_r    <= '0;
            bit_idx_r  <= 3'd0;
            parity_r   <= 1'b0;
            par_en_r   <= 1'b0;
            stop_sel_r <= STOP_ONE;
            tx_out_r   <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (send) begin
                        shreg_r    <= data_in;
                        parity_r   <= parity_calc(data_in, parity_type);
                        par_en_r   <= parity_enabled(parity_type);
                        stop_sel_r <= stop_bits;
                        bit_idx_r  <= 3'd0;
                        state_r    <= START;
                        tx_out_r   <= 1'b0;
                        busy_r     <= 1'b1;
                    end else begin
                        tx_out_r <= 1'b1;
                        busy_r   <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end_s) begin
                        state_r  <= DATA;
                        tx_out_r <= shreg_r[0];
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        if (bit_idx_r == LAST_IDX) begin
                            if (par_en_r) begin
                                state_r  <= PARITY;
                                tx_out_r <= parity_r;
                            end else begin
                                state_r  <= STOP1;
                                tx_out_r <= 1'b1;
                            end
                        end else begin
                            // Next data bit is the one that moves into shreg_r[0].
                            shreg_r   <= {1'b0, shreg_r[DATA_WIDTH-1:1]};
                            tx_out_r  <= shreg_r[1];
                            bit_idx_r <= bit_idx_r + IDX_ONE;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end_s) begin
                        state_r  <= STOP1;
                        tx_out_r <= 1'b1;
                    end
                end
                STOP1: begin
                    if (bit_end_s) begin
                        if (stop_sel_r == STOP_ONE) begin
                            state_r  <= IDLE;
                            busy_r   <= 1'b0;
                            done_r   <= 1'b1;
                            tx_out_r <= 1'b1;
                        end else begin
                            state_r  <= STOP2;
                            tx_out_r <= 1'b1;
                        end
                    end
                end
                STOP2: begin
                    if (bit_end_s) begin
                        state_r  <= IDLE;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                        tx_out_r <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    busy_r   <= 1'b0;
                    tx_out_r <= 1'b1;
                end
            endcase
        end
    end

    assign tx_out = tx_out_r;
    assign busy   = busy_r;
    assign done   = done_r;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with CLKS_PER_BIT=4. Expected line patterns
// are written out by hand as bit strings in transmission order (start first).
module tb_uart_tx_ctrl;

    localparam int CPB = 4;

    logic       clock;
    logic       reset_n;
    logic       send;
    logic [7:0] data_in;
    logic [1:0] parity_type;
    logic       stop_bits;
    logic       tx_out;
    logic       busy;
    logic       done;

    int vec_cnt = 0;
    int err_cnt = 0;

    uart_tx_ctrl #(
        .CLKS_PER_BIT(CPB),
        .DATA_WIDTH  (8)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .send        (send),
        .data_in     (data_in),
        .parity_type (parity_type),
        .stop_bits   (stop_bits),
        .tx_out      (tx_out),
        .busy        (busy),
        .done        (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reset applied, then released with no send: line idle throughout.
    task automatic test_reset();
        reset_n     = 1'b0;
        send        = 1'b0;
        data_in     = 8'h00;
        parity_type = 2'b00;
        stop_bits   = 1'b0;
        #7;
        vec_cnt++;
        if (tx_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_hold: tx_out=%b busy=%b done=%b, required 1 0 0", tx_out, busy, done);
        end
        #3;
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            vec_cnt++;
            if (tx_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
                err_cnt++;
                $display("FAIL reset_idle[%0d]: tx_out=%b busy=%b done=%b, required 1 0 0", i, tx_out, busy, done);
            end
        end
    endtask

    // Even parity, one stop bit: 11 bits, done 44 cycles after accept.
    task automatic test_even_parity();
        logic [11:0] frame_v;
        int          n;
        frame_v = 12'b0_01110100001;
        n       = 11;
        @(negedge clock);
        data_in = 8'b00010111; parity_type = 2'b10; stop_bits = 1'b0; send = 1'b1;
        @(posedge clock);
        for (int i = 0; i < n * CPB; i++) begin
            @(negedge clock);
            vec_cnt++;
            if (tx_out !== frame_v[n - 1 - i / CPB] || busy !== 1'b1 || done !== 1'b0) begin
                err_cnt++;
                $display("FAIL even_cyc%0d: tx_out=%b busy=%b done=%b, required %b 1 0",
                         i, tx_out, busy, done, frame_v[n - 1 - i / CPB]);
            end
            if (i == 0) send = 1'b0;
        end
        @(negedge clock);
        vec_cnt++;
        if (done !== 1'b1 || busy !== 1'b0 || tx_out !== 1'b1) begin
            err_cnt++;
            $display("FAIL even_done: done=%b busy=%b tx_out=%b, required 1 0 1", done, busy, tx_out);
        end
        @(negedge clock);
        vec_cnt++;
        if (done !== 1'b0) begin
            err_cnt++;
            $display("FAIL even_done_width: done=%b, required 0", done);
        end
    endtask

    // Odd parity adds a 1; types 00 and 11 drop the parity bit (done at 40).
    task automatic test_parity_types();
        logic [1:0]  types_v  [3];
        logic [11:0] frames_v [3];
        int          lens_v   [3];
        types_v[0] = 2'b01; frames_v[0] = 12'b0_01110100011; lens_v[0] = 11;
        types_v[1] = 2'b00; frames_v[1] = 12'b00_0111010001; lens_v[1] = 10;
        types_v[2] = 2'b11; frames_v[2] = 12'b00_0111010001; lens_v[2] = 10;
        for (int t = 0; t < 3; t++) begin
            @(negedge clock);
            data_in = 8'b00010111; parity_type = types_v[t]; stop_bits = 1'b0; send = 1'b1;
            @(posedge clock);
            for (int i = 0; i < lens_v[t] * CPB; i++) begin
                @(negedge clock);
                vec_cnt++;
                if (tx_out !== frames_v[t][lens_v[t] - 1 - i / CPB] || busy !== 1'b1 || done !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL ptype%b_cyc%0d: tx_out=%b busy=%b done=%b, required %b 1 0",
                             types_v[t], i, tx_out, busy, done, frames_v[t][lens_v[t] - 1 - i / CPB]);
                end
                if (i == 0) send = 1'b0;
            end
            @(negedge clock);
            vec_cnt++;
            if (done !== 1'b1 || busy !== 1'b0 || tx_out !== 1'b1) begin
                err_cnt++;
                $display("FAIL ptype%b_done: done=%b busy=%b tx_out=%b, required 1 0 1",
                         types_v[t], done, busy, tx_out);
            end
        end
    endtask

    // Two stop bits, done at 48; a send pulse mid-frame is ignored.
    task automatic test_two_stop_ignore_send();
        logic [11:0] frame_v;
        int          n;
        frame_v = 12'b010010101011;
        n       = 12;
        @(negedge clock);
        data_in = 8'b10101001; parity_type = 2'b10; stop_bits = 1'b1; send = 1'b1;
        @(posedge clock);
        for (int i = 0; i < n * CPB; i++) begin
            @(negedge clock);
            vec_cnt++;
            if (tx_out !== frame_v[n - 1 - i / CPB] || busy !== 1'b1 || done !== 1'b0) begin
                err_cnt++;
                $display("FAIL stop2_cyc%0d: tx_out=%b busy=%b done=%b, required %b 1 0",
                         i, tx_out, busy, done, frame_v[n - 1 - i / CPB]);
            end
            if (i == 0) send = 1'b0;
            if (i == 20) begin
                send = 1'b1; data_in = 8'hFF; parity_type = 2'b01; stop_bits = 1'b0;
            end
            if (i == 21) send = 1'b0;
        end
        @(negedge clock);
        vec_cnt++;
        if (done !== 1'b1 || busy !== 1'b0 || tx_out !== 1'b1) begin
            err_cnt++;
            $display("FAIL stop2_done: done=%b busy=%b tx_out=%b, required 1 0 1", done, busy, tx_out);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            vec_cnt++;
            if (tx_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
                err_cnt++;
                $display("FAIL no_second_frame[%0d]: tx_out=%b busy=%b done=%b, required 1 0 0",
                         i, tx_out, busy, done);
            end
        end
    endtask

    // send held across done: second start bit right after done; inputs changed in flight.
    task automatic test_back_to_back();
        logic [11:0] frame_a_v;
        logic [11:0] frame_b_v;
        int          n;
        frame_a_v = 12'b0_00101101011;
        frame_b_v = 12'b0_01100001111;
        n         = 11;
        @(negedge clock);
        data_in = 8'h5A; parity_type = 2'b01; stop_bits = 1'b0; send = 1'b1;
        @(posedge clock);
        for (int i = 0; i < n * CPB; i++) begin
            @(negedge clock);
            vec_cnt++;
            if (tx_out !== frame_a_v[n - 1 - i / CPB] || busy !== 1'b1 || done !== 1'b0) begin
                err_cnt++;
                $display("FAIL b2b_a_cyc%0d: tx_out=%b busy=%b done=%b, required %b 1 0",
                         i, tx_out, busy, done, frame_a_v[n - 1 - i / CPB]);
            end
            if (i == 0) begin
                data_in = 8'hC3; parity_type = 2'b00; stop_bits = 1'b1;
            end
        end
        @(negedge clock);
        vec_cnt++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_a_done: done=%b busy=%b, required 1 0", done, busy);
        end
        for (int i = 0; i < n * CPB; i++) begin
            @(negedge clock);
            vec_cnt++;
            if (tx_out !== frame_b_v[n - 1 - i / CPB] || busy !== 1'b1 || done !== 1'b0) begin
                err_cnt++;
                $display("FAIL b2b_b_cyc%0d: tx_out=%b busy=%b done=%b, required %b 1 0",
                         i, tx_out, busy, done, frame_b_v[n - 1 - i / CPB]);
            end
            if (i == 0) send = 1'b0;
        end
        @(negedge clock);
        vec_cnt++;
        if (done !== 1'b1 || busy !== 1'b0 || tx_out !== 1'b1) begin
            err_cnt++;
            $display("FAIL b2b_b_done: done=%b busy=%b tx_out=%b, required 1 0 1", done, busy, tx_out);
        end
    endtask

    // Reset during data bit 3 aborts the frame; the next frame is complete.
    task automatic test_reset_mid_frame();
        logic [11:0] frame_a_v;
        logic [11:0] frame_b_v;
        int          n;
        frame_a_v = 12'b00_0000000001;
        frame_b_v = 12'b000001111011;
        @(negedge clock);
        data_in = 8'h00; parity_type = 2'b00; stop_bits = 1'b0; send = 1'b1;
        @(posedge clock);
        for (int i = 0; i < 18; i++) begin
            @(negedge clock);
            vec_cnt++;
            if (tx_out !== frame_a_v[9 - i / CPB] || busy !== 1'b1) begin
                err_cnt++;
                $display("FAIL abort_pre_cyc%0d: tx_out=%b busy=%b, required %b 1",
                         i, tx_out, busy, frame_a_v[9 - i / CPB]);
            end
            if (i == 0) send = 1'b0;
        end
        #1;
        reset_n = 1'b0;
        #1;
        vec_cnt++;
        if (tx_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            err_cnt++;
            $display("FAIL abort_async: tx_out=%b busy=%b done=%b, required 1 0 0", tx_out, busy, done);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            vec_cnt++;
            if (tx_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
                err_cnt++;
                $display("FAIL abort_idle[%0d]: tx_out=%b busy=%b done=%b, required 1 0 0",
                         i, tx_out, busy, done);
            end
            if (i == 3) reset_n = 1'b1;
        end
        n = 12;
        data_in = 8'hF0; parity_type = 2'b10; stop_bits = 1'b1; send = 1'b1;
        @(posedge clock);
        for (int i = 0; i < n * CPB; i++) begin
            @(negedge clock);
            vec_cnt++;
            if (tx_out !== frame_b_v[n - 1 - i / CPB] || busy !== 1'b1 || done !== 1'b0) begin
                err_cnt++;
                $display("FAIL post_rst_cyc%0d: tx_out=%b busy=%b done=%b, required %b 1 0",
                         i, tx_out, busy, done, frame_b_v[n - 1 - i / CPB]);
            end
            if (i == 0) send = 1'b0;
        end
        @(negedge clock);
        vec_cnt++;
        if (done !== 1'b1 || busy !== 1'b0 || tx_out !== 1'b1) begin
            err_cnt++;
            $display("FAIL post_rst_done: done=%b busy=%b tx_out=%b, required 1 0 1", done, busy, tx_out);
        end
    endtask

    initial begin
        test_reset();
        test_even_parity();
        test_parity_types();
        test_two_stop_ignore_send();
        test_back_to_back();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
